// File: rtl/cpu_pkg.sv
// Shared constants and types for the Zicsr access unit: funct3 codes,
// FSM state encodings and the read-only CSR address prefix.
package cpu_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] RO_PREFIX = 2'b11;

  typedef struct packed {
    logic [2:0] funct3;
    logic [4:0] idx;
  } csr_req_t;

endpackage

// File: rtl/cpu_csr_alu.sv
// Combinational Zicsr value computation: new CSR value, whether a write is
// requested, and whether funct3 is an illegal encoding.
module cpu_csr_alu
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] operand,
  input  logic [4:0]      rs1_idx,
  output logic [XLEN-1:0] new_val,
  output logic            write_en,
  output logic            illegal_op
);

  // Set/clear forms with rs1 field zero are pure reads and must not write.
  always_comb begin
    new_val    = operand;
    write_en   = 1'b1;
    illegal_op = 1'b0;
    case (funct3)
      F3_RW, F3_RWI: ;
      F3_RS, F3_RSI: begin
        new_val  = old | operand;
        write_en = (rs1_idx != 5'd0);
      end
      F3_RC, F3_RCI: begin
        new_val  = old & ~operand;
        write_en = (rs1_idx != 5'd0);
      end
      default: illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_csr_unit.sv
// Zicsr executor: latches a request, reads the CSR, writes back the new
// value one cycle later and returns the old value with a done pulse.
module cpu_csr_unit
  import cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] csr_addr_in,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [4:0]        rs1_idx,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [XLEN-1:0]   rd_data,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_wr,
  input  logic [XLEN-1:0]   csr_rdata
);

  logic [1:0]      state;
  csr_req_t        req_q;
  logic [XLEN-1:0] op_q;
  logic [XLEN-1:0] old_q;
  logic            ill_q;

  logic [XLEN-1:0] alu_new;
  logic            alu_wen;
  logic            alu_ill;
  logic            ill_rd;

  cpu_csr_alu #(.XLEN(XLEN)) u_alu (
    .funct3     (req_q.funct3),
    .old        (csr_rdata),
    .operand    (op_q),
    .rs1_idx    (req_q.idx),
    .new_val    (alu_new),
    .write_en   (alu_wen),
    .illegal_op (alu_ill)
  );

  // Writing a read-only CSR is illegal; a pure read of one is allowed.
  assign ill_rd = alu_ill || (alu_wen && (csr_addr[ADDR_W-1 -: 2] == RO_PREFIX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_q     <= '0;
      op_q      <= '0;
      old_q     <= '0;
      ill_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      rd_data   <= '0;
      csr_addr  <= '0;
      csr_wdata <= '0;
      csr_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            req_q.funct3 <= funct3;
            req_q.idx    <= rs1_idx;
            op_q         <= funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
            csr_addr     <= csr_addr_in;
            busy         <= 1'b1;
            state        <= READ;
          end
        end
        READ: begin
          old_q     <= csr_rdata;
          csr_wdata <= alu_new;
          csr_wr    <= alu_wen && !ill_rd;
          ill_q     <= ill_rd;
          state     <= WRITE;
        end
        WRITE: begin
          csr_wr  <= 1'b0;
          done    <= 1'b1;
          illegal <= ill_q;
          rd_data <= ill_q ? '0 : old_q;
          state   <= DONE;
        end
        default: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_csr_unit.sv
// Bench for cpu_csr_unit with a small behavioural CSR file attached to the
// csr_addr/csr_wdata/csr_wr/csr_rdata side.
module tb_cpu_csr_unit;

  localparam logic [31:0] INSTRET_VAL = 32'h0000_0777;
  localparam logic [31:0] TIME_VAL    = 32'h0000_1111;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdl_rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [11:0] csr_addr_in;
  logic [31:0] rs1_data;
  logic [4:0]  rs1_idx;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [31:0] rd_data;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wr;
  logic [31:0] csr_rdata;

  logic [31:0] sscratch;
  logic [31:0] sie;
  logic [31:0] mscratch;
  logic [31:0] cycle_cnt;
  int          wr_count;
  int          done_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  idx;
    logic [31:0] rd;
    logic        ill;
    int          wr;
    logic        use_cyc;
    logic        chk_after;
    logic [31:0] after;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];

  cpu_csr_unit #(.XLEN(32), .ADDR_W(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .funct3      (funct3),
    .csr_addr_in (csr_addr_in),
    .rs1_data    (rs1_data),
    .rs1_idx     (rs1_idx),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .rd_data     (rd_data),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_wr      (csr_wr),
    .csr_rdata   (csr_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdl_read(input logic [11:0] a);
    case (a)
      12'h140: return sscratch;
      12'h104: return sie;
      12'h340: return mscratch;
      12'hC00: return cycle_cnt;
      12'hC01: return TIME_VAL;
      12'hC02: return INSTRET_VAL;
      default: return 32'h0;
    endcase
  endfunction

  always_comb csr_rdata = mdl_read(csr_addr);

  always @(posedge clk or negedge mdl_rst_n) begin
    if (!mdl_rst_n) begin
      sscratch  <= 32'h1234_5678;
      sie       <= 32'h0000_0200;
      mscratch  <= 32'hA5A5_A5A5;
      cycle_cnt <= 32'h0000_0100;
      wr_count  <= 0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (csr_wr) begin
        wr_count <= wr_count + 1;
        case (csr_addr)
          12'h140: sscratch <= csr_wdata;
          12'h104: sie      <= csr_wdata;
          12'h340: mscratch <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  always @(posedge clk or negedge mdl_rst_n) begin
    if (!mdl_rst_n) done_cnt <= 0;
    else if (done)  done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] r, input logic [4:0] i);
    funct3      = f3;
    csr_addr_in = a;
    rs1_data    = r;
    rs1_idx     = i;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int   wr0, lat;
    exp_t e;
    @(negedge clk);
    drive(v.f3, v.addr, v.rs1, v.idx);
    start = 1'b1;
    wr0 = wr_count;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d busy", n), {31'b0, busy}, 32'd1);
    e.rd  = v.use_cyc ? cycle_cnt : v.rd;
    e.ill = v.ill;
    sb.push_back(e);
    lat = 1;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", n), 32'(lat), 32'd3);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("v%0d rd_data", n), rd_data, e.rd);
      chk($sformatf("v%0d illegal", n), {31'b0, illegal}, {31'b0, e.ill});
    end else begin
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", n), {31'b0, done}, 32'd0);
    chk($sformatf("v%0d busy_after", n), {31'b0, busy}, 32'd0);
    chk($sformatf("v%0d rd_held", n), rd_data, e.rd);
    chk($sformatf("v%0d wr_pulses", n), 32'(wr_count - wr0), 32'(v.wr));
    if (v.chk_after)
      chk($sformatf("v%0d csr_after", n), mdl_read(v.addr), v.after);
  endtask

  initial begin
    int   wr0, dn0;
    vec_t v;
    exp_t e;

    vecs[0]  = '{3'b001, 12'h140, 32'hDEAD_BEEF, 5'd1,  32'h1234_5678, 1'b0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[1]  = '{3'b010, 12'h104, 32'h0000_0022, 5'd5,  32'h0000_0200, 1'b0, 1, 1'b0, 1'b1, 32'h0000_0222};
    vecs[2]  = '{3'b011, 12'h104, 32'h0000_0200, 5'd6,  32'h0000_0222, 1'b0, 1, 1'b0, 1'b1, 32'h0000_0022};
    vecs[3]  = '{3'b110, 12'hC00, 32'hFFFF_FFFF, 5'd0,  32'h0,         1'b0, 0, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{3'b101, 12'hC02, 32'h0,         5'd5,  32'h0,         1'b1, 0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{3'b100, 12'h140, 32'h1111_2222, 5'd3,  32'h0,         1'b1, 0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{3'b101, 12'h340, 32'hFFFF_0000, 5'h1F, 32'hA5A5_A5A5, 1'b0, 1, 1'b0, 1'b1, 32'h0000_001F};
    vecs[7]  = '{3'b111, 12'h340, 32'h0,         5'd3,  32'h0000_001F, 1'b0, 1, 1'b0, 1'b1, 32'h0000_001C};
    vecs[8]  = '{3'b010, 12'h340, 32'hFFFF_FFFF, 5'd0,  32'h0000_001C, 1'b0, 0, 1'b0, 1'b1, 32'h0000_001C};
    vecs[9]  = '{3'b001, 12'hC01, 32'h0000_0042, 5'd2,  32'h0,         1'b1, 0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{3'b000, 12'h104, 32'h0000_0001, 5'd1,  32'h0,         1'b1, 0, 1'b0, 1'b1, 32'h0000_0022};
    vecs[11] = '{3'b110, 12'hC02, 32'h0,         5'd0,  INSTRET_VAL,   1'b0, 0, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{3'b010, 12'hC02, 32'h0000_00FF, 5'd0,  INSTRET_VAL,   1'b0, 0, 1'b0, 1'b0, 32'h0};

    rst = 1'b0;
    mdl_rst_n = 1'b0;
    start = 1'b0;
    drive(3'b000, 12'h000, 32'h0, 5'd0);
    #1;
    chk("reset busy",      {31'b0, busy},    32'd0);
    chk("reset done",      {31'b0, done},    32'd0);
    chk("reset illegal",   {31'b0, illegal}, 32'd0);
    chk("reset rd_data",   rd_data,          32'd0);
    chk("reset csr_addr",  {20'b0, csr_addr}, 32'd0);
    chk("reset csr_wdata", csr_wdata,        32'd0);
    chk("reset csr_wr",    {31'b0, csr_wr},  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mdl_rst_n = 1'b1;

    for (int k = 0; k < 13; k++) run_vec(vecs[k], k);

    // start held high through READ, WRITE and DONE with a different request
    @(negedge clk);
    drive(3'b001, 12'h140, 32'h0000_0055, 5'd1);
    start = 1'b1;
    wr0 = wr_count;
    dn0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    e.rd = 32'hDEAD_BEEF;
    e.ill = 1'b0;
    sb.push_back(e);
    drive(3'b001, 12'h340, 32'h0000_0099, 5'd2);
    @(negedge clk);
    @(negedge clk);
    chk("busy_start done", {31'b0, done}, 32'd1);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      chk("busy_start rd_data", rd_data, e.rd);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_start done_count", 32'(done_cnt - dn0), 32'd1);
    chk("busy_start wr_pulses",  32'(wr_count - wr0), 32'd1);
    chk("busy_start sscratch",   sscratch, 32'h0000_0055);
    chk("busy_start mscratch",   mscratch, 32'h0000_001C);
    chk("busy_start idle",       {31'b0, busy}, 32'd0);

    // reset asserted in the WRITE cycle
    @(negedge clk);
    drive(3'b001, 12'h140, 32'hCAFE_F00D, 5'd1);
    start = 1'b1;
    wr0 = wr_count;
    dn0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_mid wr_before", {31'b0, csr_wr}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid csr_wr", {31'b0, csr_wr}, 32'd0);
    chk("rst_mid busy",   {31'b0, busy},   32'd0);
    chk("rst_mid done",   {31'b0, done},   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid no_done",  32'(done_cnt - dn0), 32'd0);
    chk("rst_mid no_write", 32'(wr_count - wr0), 32'd0);
    chk("rst_mid sscratch", sscratch, 32'h0000_0055);

    v = '{3'b001, 12'h140, 32'h0BAD_F00D, 5'd4, 32'h0000_0055, 1'b0, 1, 1'b0, 1'b1, 32'h0BAD_F00D};
    run_vec(v, 99);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
